fft_output_reorder: RTL and testbench
=====================================

// Module: fft_output_reorder
// PURPOSE
//  Receive end of the 32-point MDC FFT dual-lane output (up/down lanes, bit-reversed order).
//  Ping-pong buffers each 32-bin frame and re-emits it as one serial, natural-order
//  stream X[0]..X[31] with valid/ready handshake. Sits directly after the last MDC stage.
// PARAMETERS
//  W   9   sample width per re/im component (signed, two's complement)
//  N   32  FFT size; fixed, other values unsupported (lane mapping below is for N=32)
// PORTS
//  clk         in   1  single clock, all logic on rising edge
//  rst_n       in   1  reset: synchronous, active-high (1 = reset), despite the suffix
//  in_valid    in   1  up/down lane pair valid this cycle
//  in_ready    out  1  block can accept a pair this cycle
//  in_first    in   1  qualifies first pair (k=0) of a frame
//  in_up_re    in   W  up lane real
//  in_up_im    in   W  up lane imag
//  in_dn_re    in   W  down lane real
//  in_dn_im    in   W  down lane imag
//  out_valid   out  1  out_* hold a valid bin
//  out_ready   in   1  consumer accepts bin when out_valid & out_ready
//  out_re      out  W  bin real
//  out_im      out  W  bin imag
//  out_index   out  5  bin number 0..31
//  out_first   out  1  high with bin 0
//  out_last    out  1  high with bin 31
//  frame_err   out  1  sticky: partial frame discarded
// BEHAVIOUR
//  - Input transfer = in_valid & in_ready. Pair k (0..15) of a frame:
//    up -> X[rev4(k)], down -> X[rev4(k)+16]; rev4 = 4-bit bit reversal.
//    Both written in the same cycle to the current write bank.
//  - Two banks x 32 entries x 2W bits. Per-bank state: FREE -> FILLING -> FULL -> DRAINING -> FREE.
//    FREE->FILLING on accepted pair k=0. FILLING->FULL on accepted pair k=15 (wr_cnt wraps to 0,
//    write bank toggles). FULL->DRAINING when read side selects it. DRAINING->FREE when bin 31 is accepted.
//  - in_ready = 1 iff write bank is FREE or FILLING. Both banks FULL/DRAINING -> in_ready=0.
//  - Pair accepted with in_first=0 while wr_cnt=0: dropped, no write, frame_err set.
//  - in_first=1 with wr_cnt!=0: partial frame discarded, pair written as k=0 of the
//    same bank, frame_err set.
//  - Read: bins in natural order 0..31 from the oldest FULL bank. Output regs hold
//    value while out_valid & !out_ready.
//    Next bin loads on accept; no bubble between bins or between back-to-back frames.
//  - Latency: bank goes FULL at edge E -> out_valid=1 with bin 0 after edge E+1.
//  - Sustained throughput: 1 frame / 32 cycles; input bursts of 16 pairs accepted at full rate.
//  - Same-cycle free of a bank by read and k=15 write into the other bank: both take effect,
//    and in_ready stays 1.
//  - Reset (any time, incl. mid-frame): both banks FREE, wr_cnt=rd_cnt=0, write/read bank=0,
//    in_ready=1 on the cycle after reset deasserts, out_valid=0, out_re/out_im/out_index=0,
//    out_first=out_last=0, frame_err=0. Buffer contents are not cleared.
//  - Data is passed unmodified (no scaling, rounding or saturation).
// CONFIGURATION
//  FFT_REORDER_FRAME_CNT_EN defined: adds output frame_cnt [7:0].
//    Reset 0, +1 when bin 31 is accepted, wraps 255->0.
//  Not defined: port and counter absent. All other behaviour identical.
// TESTING
//  1 Reset, one frame, pair k gives up=k*2, dn=k*2+1 (re), im=-re, out_ready=1 ->
//    32 bins in order, out_re[rev4(k)]=2k, out_re[rev4(k)+16]=2k+1, out_first@0, out_last@31.
//  2 Three frames back-to-back with no gaps, out_ready=0 for 40 cycles -> in_ready drops
//    after pair 31 (2 banks full). Release -> 96 bins, no loss or duplication.
//  3 out_ready toggling 1/0 every cycle -> each bin held while stalled; 32 distinct bins per frame.
//  4 in_first=1 at k=7 -> frame_err=1. Next 16 pairs form a complete frame, output correct.
//  5 rst_n=1 at bin 10 of drain -> next cycle out_valid=0, in_ready=1.
//    A new frame is output correctly.
//  6 FFT_REORDER_FRAME_CNT_EN defined, 257 frames -> frame_cnt=1. Undefined: build with no port.

Source files
------------

// File: rtl/fft_output_reorder.sv
// ---------------------------------------------------------------------------
// fft_output_reorder
//
// Receive end of a 32-point MDC FFT. The last MDC stage delivers each frame as
// 16 up/down lane pairs in bit-reversed order. This block ping-pong buffers
// each 32-bin frame and re-emits it as one serial, natural-order stream
// X[0]..X[31] with a valid/ready handshake. Data is passed through unmodified.
//
// Lane mapping for pair k (0..15) of a frame:
//   up lane   -> X[rev4(k)]
//   down lane -> X[rev4(k) + 16]
//
// Ports
//   clk        in   1  single clock, all logic on rising edge
//   rst_n      in   1  synchronous reset, ACTIVE-HIGH despite the name
//   in_valid   in   1  up/down lane pair valid this cycle
//   in_ready   out  1  block can accept a pair this cycle
//   in_first   in   1  marks pair k=0 of a frame
//   in_up_re   in   W  up lane real
//   in_up_im   in   W  up lane imag
//   in_dn_re   in   W  down lane real
//   in_dn_im   in   W  down lane imag
//   out_valid  out  1  out_* hold a valid bin
//   out_ready  in   1  consumer accepts the bin when out_valid & out_ready
//   out_re     out  W  bin real
//   out_im     out  W  bin imag
//   out_index  out  5  bin number 0..31
//   out_first  out  1  high with bin 0
//   out_last   out  1  high with bin 31
//   frame_err  out  1  sticky: a partial frame or a stray pair was discarded
//   frame_cnt  out  8  (only with FFT_REORDER_FRAME_CNT_EN) frames emitted, wraps
//
// Configuration macro
//   FFT_REORDER_FRAME_CNT_EN : when defined, adds the frame_cnt output, which
//   counts accepted bin-31 transfers modulo 256. When undefined the port and
//   counter are absent; all other behaviour is identical.
// ---------------------------------------------------------------------------
module fft_output_reorder #(
    parameter int W = 9,
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_first,
    input  logic [W-1:0] in_up_re,
    input  logic [W-1:0] in_up_im,
    input  logic [W-1:0] in_dn_re,
    input  logic [W-1:0] in_dn_im,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_re,
    output logic [W-1:0] out_im,
    output logic [4:0]   out_index,
    output logic         out_first,
    output logic         out_last,
    output logic         frame_err
`ifdef FFT_REORDER_FRAME_CNT_EN
    ,
    output logic [7:0]   frame_cnt
`endif
);

    typedef enum logic [1:0] {
        S_FREE     = 2'd0,
        S_FILLING  = 2'd1,
        S_FULL     = 2'd2,
        S_DRAINING = 2'd3
    } bank_state_t;

    // 4-bit bit reversal used to place pair k into the natural-order buffer
    function automatic logic [3:0] rev4(input logic [3:0] k);
        return {k[0], k[1], k[2], k[3]};
    endfunction

    // Two banks of N words; each word packs {re, im}
    logic [2*W-1:0] r_mem [2][N];

    bank_state_t    r_state [2];
    logic           r_wr_bank;
    logic [3:0]     r_wr_cnt;
    logic           r_rd_bank;
    logic [4:0]     r_rd_cnt;     // next bin to load into the output regs
    logic           r_frame_err;

    logic           r_out_valid;
    logic [W-1:0]   r_out_re;
    logic [W-1:0]   r_out_im;
    logic [4:0]     r_out_index;
    logic           r_out_first;
    logic           r_out_last;
`ifdef FFT_REORDER_FRAME_CNT_EN
    logic [7:0]     r_frame_cnt;
`endif

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic           w_in_fire;
    logic           w_wr_en;
    logic [3:0]     w_wr_k;
    logic [3:0]     w_wr_addr;

    // Only the write bank's own state gates acceptance, so a read-side free
    // of the other bank in the same cycle never drops in_ready.
    assign in_ready  = (r_state[r_wr_bank] == S_FREE) ||
                       (r_state[r_wr_bank] == S_FILLING);
    assign w_in_fire = in_valid && in_ready;

    // in_first restarts the frame at k=0; a non-first pair with no frame in
    // progress is dropped without writing.
    assign w_wr_k    = in_first ? 4'd0 : r_wr_cnt;
    assign w_wr_en   = w_in_fire && (in_first || (r_wr_cnt != 4'd0));
    assign w_wr_addr = rev4(w_wr_k);

    // Buffer storage is never reset; only control state is.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_bank][{1'b0, w_wr_addr}] <= {in_up_re, in_up_im};
            r_mem[r_wr_bank][{1'b1, w_wr_addr}] <= {in_dn_re, in_dn_im};
        end
    end

    // ------------------------------------------------------------------
    // Read side selection
    // ------------------------------------------------------------------
    logic           w_adv;        // output slot empty or being consumed
    logic           w_cur_drain;  // read bank currently draining
    logic           w_more;       // read bank still has bins left to load
    logic           w_other;
    logic           w_load;
    logic           w_ld_bank;
    logic [4:0]     w_ld_addr;
    logic [2*W-1:0] w_rd_word;

    assign w_adv       = !r_out_valid || out_ready;
    assign w_cur_drain = (r_state[r_rd_bank] == S_DRAINING);
    assign w_more      = w_cur_drain && (r_rd_cnt != 5'd0);
    assign w_other     = ~r_rd_bank;

    // While draining with r_rd_cnt wrapped to 0, bin 31 sits in the output
    // regs; when it is accepted the other bank can start in the same cycle,
    // which keeps back-to-back frames free of bubbles.
    always_comb begin
        w_load    = 1'b0;
        w_ld_bank = r_rd_bank;
        w_ld_addr = r_rd_cnt;
        if (w_more) begin
            w_load = 1'b1;
        end else if (w_cur_drain) begin
            if (r_state[w_other] == S_FULL) begin
                w_load    = 1'b1;
                w_ld_bank = w_other;
                w_ld_addr = 5'd0;
            end
        end else if (r_state[r_rd_bank] == S_FULL) begin
            w_load    = 1'b1;
            w_ld_addr = 5'd0;
        end
    end

    assign w_rd_word = r_mem[w_ld_bank][w_ld_addr];

    // ------------------------------------------------------------------
    // Control state and output registers
    // ------------------------------------------------------------------
    // Write and read sides never update the same bank's state in one cycle:
    // the write bank is FREE/FILLING whenever a pair fires, while the read
    // side only touches banks that are FULL or DRAINING.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state[0]  <= S_FREE;
            r_state[1]  <= S_FREE;
            r_wr_bank   <= 1'b0;
            r_wr_cnt    <= 4'd0;
            r_rd_bank   <= 1'b0;
            r_rd_cnt    <= 5'd0;
            r_frame_err <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_out_index <= 5'd0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
`ifdef FFT_REORDER_FRAME_CNT_EN
            r_frame_cnt <= 8'd0;
`endif
        end else begin
            if (w_in_fire) begin
                if (in_first) begin
                    if (r_wr_cnt != 4'd0) begin
                        r_frame_err <= 1'b1;
                    end
                    r_wr_cnt           <= 4'd1;
                    r_state[r_wr_bank] <= S_FILLING;
                end else if (r_wr_cnt == 4'd0) begin
                    r_frame_err <= 1'b1;
                end else if (r_wr_cnt == 4'd15) begin
                    r_wr_cnt           <= 4'd0;
                    r_state[r_wr_bank] <= S_FULL;
                    r_wr_bank          <= ~r_wr_bank;
                end else begin
                    r_wr_cnt <= r_wr_cnt + 4'd1;
                end
            end

            if (w_adv) begin
                // Draining with nothing left to load means bin 31 is being
                // accepted right now: release the bank.
                if (w_cur_drain && !w_more) begin
                    r_state[r_rd_bank] <= S_FREE;
                    r_rd_bank          <= w_other;
`ifdef FFT_REORDER_FRAME_CNT_EN
                    r_frame_cnt        <= r_frame_cnt + 8'd1;
`endif
                end
                if (w_load) begin
                    r_out_valid <= 1'b1;
                    r_out_re    <= w_rd_word[2*W-1:W];
                    r_out_im    <= w_rd_word[W-1:0];
                    r_out_index <= w_ld_addr;
                    r_out_first <= (w_ld_addr == 5'd0);
                    r_out_last  <= (w_ld_addr == 5'd31);
                    r_rd_cnt    <= w_ld_addr + 5'd1;
                    if (w_ld_addr == 5'd0) begin
                        r_state[w_ld_bank] <= S_DRAINING;
                    end
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_re    = r_out_re;
    assign out_im    = r_out_im;
    assign out_index = r_out_index;
    assign out_first = r_out_first;
    assign out_last  = r_out_last;
    assign frame_err = r_frame_err;
`ifdef FFT_REORDER_FRAME_CNT_EN
    assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_fft_output_reorder.sv
// ---------------------------------------------------------------------------
// tb_fft_output_reorder
//
// Scoreboard bench for fft_output_reorder. A frame model collects accepted
// lane pairs, places them by bit-reversed index into a 32-bin array and, when
// a frame completes, pushes the 32 expected bins in natural order. A monitor
// pops and compares on every output transfer and checks that stalled outputs
// hold their value.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fft_output_reorder;

    localparam int W = 9;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_first;
    logic [W-1:0] in_up_re, in_up_im, in_dn_re, in_dn_im;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_re, out_im;
    logic [4:0]   out_index;
    logic         out_first, out_last, frame_err;
`ifdef FFT_REORDER_FRAME_CNT_EN
    logic [7:0]   frame_cnt;
`endif

    always #5 clk = ~clk;

    fft_output_reorder #(.W(W), .N(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_up_re  (in_up_re),
        .in_up_im  (in_up_im),
        .in_dn_re  (in_dn_re),
        .in_dn_im  (in_dn_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_index (out_index),
        .out_first (out_first),
        .out_last  (out_last),
        .frame_err (frame_err)
`ifdef FFT_REORDER_FRAME_CNT_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );

    typedef struct {
        logic [W-1:0] re;
        logic [W-1:0] im;
        int           idx;
    } bin_t;

    bin_t         exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           n_pop = 0;
    int           rdy_mode = 0;   // 0 always ready, 1 never, 2 toggle, 3 random
    logic         mon_en = 1'b0;

    // Frame reference model state
    int           m_cnt = 0;
    logic         exp_err = 1'b0;
    logic [W-1:0] f_re[32];
    logic [W-1:0] f_im[32];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rev4(input int k);
        int r = 0;
        for (int i = 0; i < 4; i++) r = r * 2 + ((k >> i) & 1);
        return r;
    endfunction

    // Model of one accepted pair: restart on in_first, drop a stray non-first
    // pair, emit a natural-order frame once 16 pairs have been collected.
    task automatic model_accept(input logic f, input logic [W-1:0] ur, ui, dr, di);
        int k;
        bin_t b;
        k = -1;
        if (f) begin
            if (m_cnt != 0) exp_err = 1'b1;
            k = 0;
        end else if (m_cnt == 0) begin
            exp_err = 1'b1;
        end else begin
            k = m_cnt;
        end
        if (k >= 0) begin
            f_re[rev4(k)]      = ur;
            f_im[rev4(k)]      = ui;
            f_re[rev4(k) + 16] = dr;
            f_im[rev4(k) + 16] = di;
            m_cnt = k + 1;
            if (m_cnt == 16) begin
                for (int i = 0; i < 32; i++) begin
                    b.re  = f_re[i];
                    b.im  = f_im[i];
                    b.idx = i;
                    exp_q.push_back(b);
                end
                m_cnt = 0;
            end
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic send_pair(input logic f, input logic [W-1:0] ur, ui, dr, di);
        int t = 0;
        in_valid = 1'b1;
        in_first = f;
        in_up_re = ur; in_up_im = ui;
        in_dn_re = dr; in_dn_im = di;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", in_ready, 1);
        else model_accept(f, ur, ui, dr, di);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    // ramp=1: up re=2k, dn re=2k+1, im=-re; otherwise random samples
    task automatic send_frame(input bit ramp);
        logic [W-1:0] ur, ui, dr, di;
        for (int k = 0; k < 16; k++) begin
            if (ramp) begin
                ur = W'(2 * k);     ui = W'(-2 * k);
                dr = W'(2 * k + 1); di = W'(-(2 * k + 1));
            end else begin
                ur = W'($urandom); ui = W'($urandom);
                dr = W'($urandom); di = W'($urandom);
            end
            send_pair(k == 0, ur, ui, dr, di);
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending_bins", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_first = 1'b0;
        mon_en   = 1'b0;
        rst_n    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        m_cnt   = 0;
        exp_err = 1'b0;
        mon_en  = 1'b1;
    endtask

    // Consumer ready pattern, changed just after each rising edge
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            2:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: compare each transferred bin, check stalled bins are held
    logic         pv_stall = 1'b0;
    logic [W-1:0] h_re, h_im;
    logic [4:0]   h_idx;
    always @(negedge clk) begin
        bin_t e;
        if (rst_n || !mon_en) begin
            pv_stall = 1'b0;
        end else begin
            if (pv_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_re", out_re, h_re);
                chk("hold_im", out_im, h_im);
                chk("hold_index", out_index, h_idx);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_bin_queue_size", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("bin_index", out_index, e.idx);
                    chk("bin_re", out_re, e.re);
                    chk("bin_im", out_im, e.im);
                    chk("bin_first", out_first, (e.idx == 0));
                    chk("bin_last", out_last, (e.idx == 31));
                    n_pop++;
                end
            end
            pv_stall = out_valid && !out_ready;
            h_re  = out_re;
            h_im  = out_im;
            h_idx = out_index;
        end
    end

    initial begin
        int base;
        int t;
        in_valid = 1'b0; in_first = 1'b0;
        in_up_re = '0; in_up_im = '0; in_dn_re = '0; in_dn_im = '0;
        out_ready = 1'b1;
        rst_n = 1'b1;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_out_re", out_re, 0);
        chk("rst_out_im", out_im, 0);
        chk("rst_out_first", out_first, 0);
        chk("rst_out_last", out_last, 0);
        @(posedge clk); #1;

        // Single ramp frame, consumer always ready
        send_frame(1'b1);
        wait_drain();
        chk("t1_frame_err", frame_err, exp_err);

        // Three back-to-back frames with the consumer stalled for 40 cycles
        rdy_mode = 1;
        fork
            begin
                send_frame(1'b0);
                send_frame(1'b0);
                send_frame(1'b0);
            end
            begin
                repeat (36) @(negedge clk);
                chk("t2_in_ready_both_banks_busy", in_ready, 0);
                repeat (4) @(negedge clk);
                rdy_mode = 0;
            end
        join
        wait_drain();

        // Consumer toggling ready every cycle
        rdy_mode = 2;
        send_frame(1'b0);
        send_frame(1'b1);
        wait_drain();
        rdy_mode = 0;
        chk("t3_frame_err", frame_err, 0);

        // in_first restarts a partial frame at k=7
        for (int k = 0; k < 7; k++)
            send_pair(k == 0, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
        send_frame(1'b0);
        wait_drain();
        chk("t4_frame_err", frame_err, exp_err);

        // Reset in the middle of a drain
        send_frame(1'b0);
        base = n_pop;
        t = 0;
        while (n_pop < base + 10 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("t5_reached_bin10", (n_pop >= base + 10), 1);
        @(posedge clk); #1;
        mon_en = 1'b0;
        rst_n  = 1'b1;
        exp_q.delete();
        m_cnt   = 0;
        exp_err = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_out_valid_after_rst", out_valid, 0);
        chk("t5_in_ready_after_rst", in_ready, 1);
        chk("t5_frame_err_after_rst", frame_err, 0);
        mon_en = 1'b1;
        @(posedge clk); #1;
        send_frame(1'b0);
        wait_drain();

        // Stray non-first pair is dropped and flags an error
        send_pair(1'b0, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
        send_frame(1'b1);
        wait_drain();
        chk("drop_frame_err", frame_err, exp_err);

        // Random consumer back-pressure over several frames
        rdy_mode = 3;
        for (int i = 0; i < 4; i++) send_frame(1'b0);
        wait_drain();
        rdy_mode = 0;

`ifdef FFT_REORDER_FRAME_CNT_EN
        // 257 frames wrap the counter to 1
        do_reset();
        @(negedge clk);
        chk("cnt_reset", frame_cnt, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 257; i++) send_frame(1'b0);
        wait_drain();
        chk("cnt_after_257", frame_cnt, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
